// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM states, funct3 encodings and address-field widths for the data cache
package dcache_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_RESP} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(input int addr_w, input int num_lines, input int line_words);
    return addr_w - $clog2(num_lines) - $clog2(line_words) - 2;
  endfunction
endpackage

// File: rtl/dcache_lane_align.sv
// dcache_lane_align: load byte/half extraction with extension and store lane merge
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[{off_i, 3'b000} +: 8];
  assign h = word_i[{off_i[1], 4'b0000} +: 16];
  assign rdata_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
                   funct3_i == F3_H  ? {{16{h[15]}}, h} :
                   funct3_i == F3_W  ? word_i :
                   funct3_i == F3_BU ? {24'b0, b} :
                   funct3_i == F3_HU ? {16'b0, h} : '0;
  // replace only the lanes the store size covers
  always_comb begin
    merged_o = word_i;
    if (funct3_i == F3_B) merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (funct3_i == F3_H) merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    else if (funct3_i == F3_W) merged_o = wdata_i;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate L1 data cache controller
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  localparam int WW = word_w(LINE_WORDS);
  localparam int IW = idx_w(NUM_LINES);
  localparam int TW = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
  state_e state_q, state_d;
  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;
  logic [WW-1:0] beat_q, beat_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0] tag_mem [NUM_LINES];
  logic [31:0] data_mem [NUM_LINES*LINE_WORDS];
  logic [WW-1:0] word;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, unsup, last, wr_hit, wr_fill;
  logic [31:0] rdata_l, merged;
  assign word  = addr_q[WW+1:2];
  assign idx   = addr_q[IW+WW+1:WW+2];
  assign tag   = addr_q[ADDR_W-1:IW+WW+2];
  assign hit   = valid_q[idx] && tag_mem[idx] == tag;
  assign unsup = f3_q == 3'b011 || (f3_q[2] && (we_q || f3_q[1]));
  assign last  = &beat_q;
  assign cpu_ready = state_q == S_IDLE;
  assign cpu_rdata = cpu_done && !we_q ? rdata_l : '0;
  dcache_lane_align u_align (
    .funct3_i(f3_q),
    .off_i   (addr_q[1:0]),
    .word_i  (data_mem[{idx, word}]),
    .wdata_i (wdata_q),
    .rdata_o (rdata_l),
    .merged_o(merged)
  );
  // next state, memory beat outputs and array write strobes
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    cpu_done = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    wr_hit = 1'b0;
    wr_fill = 1'b0;
    case (state_q)
      S_IDLE: state_d = cpu_req ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        cpu_done = unsup || hit;
        wr_hit = hit && !unsup && we_q;
        state_d = unsup || hit ? S_IDLE : valid_q[idx] && dirty_q[idx] ? S_WB : S_REFILL;
      end
      S_WB: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = {tag_mem[idx], idx, beat_q, 2'b00};
        mem_wdata = data_mem[{idx, beat_q}];
        beat_d = mem_ack ? beat_q + 1'b1 : beat_q;
        state_d = mem_ack && last ? S_REFILL : S_WB;
      end
      S_REFILL: begin
        mem_req = 1'b1;
        mem_addr = {tag, idx, beat_q, 2'b00};
        wr_fill = mem_ack;
        beat_d = mem_ack ? beat_q + 1'b1 : beat_q;
        state_d = mem_ack && last ? S_RESP : S_REFILL;
      end
      S_RESP: begin
        cpu_done = 1'b1;
        wr_hit = we_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // control state, request capture and line status bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      if (state_q == S_IDLE && cpu_req) begin
        we_q <= cpu_we;
        f3_q <= cpu_funct3;
        addr_q <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      if (wr_hit) dirty_q[idx] <= 1'b1;
      if (wr_fill && last) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end
  // data and tag arrays; contents survive reset, writes are suppressed while in it
  always_ff @(posedge clk) begin
    if (!rst && wr_hit) data_mem[{idx, word}] <= merged;
    if (!rst && wr_fill) data_mem[{idx, beat_q}] <= mem_rdata;
    if (!rst && wr_fill && last) tag_mem[idx] <= tag;
  end
endmodule
